// File: rtl/sine_sched_pkg.sv
// Shared widths and FSM state encoding for the sine voice scheduler and its phase fold helper.
package sine_sched_pkg;

    localparam int PHASE_W  = 22;
    localparam int STEP_W   = 20;
    localparam int ROM_AW   = 10;
    localparam int SAMPLE_W = 16;
    localparam int FRAC_W   = PHASE_W - 2 - ROM_AW;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/sine_phase_fold.sv
// Folds the integer part of a 22-bit phase into a quarter-wave ROM address plus a sign flag.
module sine_phase_fold
    import sine_sched_pkg::*;
(
    input  logic [PHASE_W-1:FRAC_W] i_phase,
    output logic [ROM_AW-1:0]       o_rom_addr,
    output logic                    o_negate
);

    always_comb begin
        o_negate   = i_phase[PHASE_W-1];
        o_rom_addr = i_phase[PHASE_W-2] ? ~i_phase[PHASE_W-3:FRAC_W] : i_phase[PHASE_W-3:FRAC_W];
    end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one registered sine ROM across NUM_VOICES phase accumulators and mixes them.
// Optional sticky request-while-busy flag enabled by defining SINE_SCHED_OVERRUN_EN.
module sine_voice_scheduler
    import sine_sched_pkg::*;
#(
    parameter int NUM_VOICES  = 3,
    parameter int VOICE_SHIFT = $clog2(NUM_VOICES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         generate_next,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic [NUM_VOICES*STEP_W-1:0] step_size,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_dout,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         sample_ready,
    output logic                         busy
`ifdef SINE_SCHED_OVERRUN_EN
    ,
    output logic                         overrun
`endif
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [IDX_W-1:0]           r_idx;
    logic [NUM_VOICES-1:0]      r_en;
    logic [STEP_W-1:0]          r_step  [NUM_VOICES];
    logic [PHASE_W-1:0]         r_phase [NUM_VOICES];
    logic signed [ACC_W-1:0]    r_acc;
    logic [SAMPLE_W-1:0]        r_sample;

    logic [PHASE_W-1:0]         w_cur_phase;
    logic [ROM_AW-1:0]          w_fold_addr;
    logic                       w_negate;
    logic                       w_last;
    logic signed [ACC_W-1:0]    w_mag;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    w_acc_next;

    assign w_cur_phase = r_phase[r_idx];
    assign w_last      = (r_idx == IDX_W'(NUM_VOICES - 1));

    sine_phase_fold u_fold (
        .i_phase    (w_cur_phase[PHASE_W-1:FRAC_W]),
        .o_rom_addr (w_fold_addr),
        .o_negate   (w_negate)
    );

    always_comb begin
        w_mag      = $signed({{(ACC_W-SAMPLE_W){1'b0}}, rom_dout});
        w_term     = '0;
        if (r_en[r_idx]) begin
            w_term = w_negate ? -w_mag : w_mag;
        end
        w_acc_next = r_acc + w_term;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (generate_next) w_state_next = ADDR;
            ADDR: w_state_next = ACC;
            ACC:  w_state_next = w_last ? OUT : ADDR;
            OUT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_en     <= '0;
            r_acc    <= '0;
            r_sample <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                r_step[i]  <= '0;
                r_phase[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (generate_next) begin
                        r_en  <= voice_en;
                        r_acc <= '0;
                        r_idx <= '0;
                        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                            r_step[i] <= step_size[i*STEP_W +: STEP_W];
                        end
                    end
                end
                ACC: begin
                    r_acc <= w_acc_next;
                    // A disabled voice parks at phase 0 so re-enabling restarts the note cleanly.
                    r_phase[r_idx] <= r_en[r_idx] ? (w_cur_phase + {2'b00, r_step[r_idx]}) : '0;
                    if (w_last) begin
                        // Sample is loaded on the way into OUT so it is valid alongside sample_ready.
                        r_sample <= SAMPLE_W'(w_acc_next >>> VOICE_SHIFT);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr     = (r_state == ADDR) ? w_fold_addr : '0;
    assign sample       = r_sample;
    assign sample_ready = (r_state == OUT);
    assign busy         = (r_state != IDLE);

`ifdef SINE_SCHED_OVERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (generate_next && busy) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
